// File: rtl/writeback_arbiter.sv
// Writeback stage: per-source completion FIFOs merged round-robin into one
// registered regfile write port, with flush, $zero suppression and a
// retired-instruction counter.
module writeback_arbiter #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  localparam int unsigned SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic [NUM_SRC-1:0]          src_valid,
  output logic [NUM_SRC-1:0]          src_ready,
  input  logic [NUM_SRC*ADDR_W-1:0]   src_pc,
  input  logic [NUM_SRC-1:0]          src_reg_write,
  input  logic [NUM_SRC*REG_AW-1:0]   src_reg_dst,
  input  logic [NUM_SRC*DATA_W-1:0]   src_wdata,
  output logic                        wb_valid,
  output logic [SRC_W-1:0]            wb_src,
  output logic [ADDR_W-1:0]           wb_pc,
  output logic                        wb_reg_write,
  output logic [REG_AW-1:0]           wb_reg_dst,
  output logic [DATA_W-1:0]           wb_wdata,
  output logic [31:0]                 retired_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  // FIFO storage, one bank per source
  logic [ADDR_W-1:0] pc_mem   [NUM_SRC][DEPTH];
  logic              rw_mem   [NUM_SRC][DEPTH];
  logic [REG_AW-1:0] dst_mem  [NUM_SRC][DEPTH];
  logic [DATA_W-1:0] data_mem [NUM_SRC][DEPTH];

  logic [PTR_W-1:0] wr_ptr_q [NUM_SRC];
  logic [PTR_W-1:0] wr_ptr_d [NUM_SRC];
  logic [PTR_W-1:0] rd_ptr_q [NUM_SRC];
  logic [PTR_W-1:0] rd_ptr_d [NUM_SRC];

  logic [NUM_SRC-1:0] empty, full, push, pop;

  logic             grant_valid;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W-1:0] last_grant_q, last_grant_d;

  logic              head_rw;
  logic [ADDR_W-1:0] head_pc;
  logic [REG_AW-1:0] head_dst;
  logic [DATA_W-1:0] head_data;

  logic              wb_valid_q, wb_valid_d;
  logic [SRC_W-1:0]  wb_src_q, wb_src_d;
  logic [ADDR_W-1:0] wb_pc_q, wb_pc_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic [REG_AW-1:0] wb_reg_dst_q, wb_reg_dst_d;
  logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;
  logic [31:0]       retired_q, retired_d;

  // FIFO status; ready depends only on occupancy, so a full FIFO stays
  // not-ready even in a cycle where it pops
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full[i]  = (wr_ptr_q[i][PTR_W-1] != rd_ptr_q[i][PTR_W-1]) &&
                 (wr_ptr_q[i][IDX_W-1:0] == rd_ptr_q[i][IDX_W-1:0]);
      push[i]  = src_valid[i] && !full[i] && !flush;
    end
  end

  assign src_ready = ~full;

  // Round-robin pick: lowest requester above last_grant, else lowest overall
  always_comb begin
    logic             hi_valid;
    logic [SRC_W-1:0] hi_idx;
    logic [SRC_W-1:0] lo_idx;
    hi_valid    = 1'b0;
    hi_idx      = '0;
    lo_idx      = '0;
    grant_valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (!empty[i]) begin
        grant_valid = 1'b1;
        lo_idx      = SRC_W'(i);
        if (SRC_W'(i) > last_grant_q) begin
          hi_valid = 1'b1;
          hi_idx   = SRC_W'(i);
        end
      end
    end
    grant_idx = hi_valid ? hi_idx : lo_idx;
  end

  // Head-entry mux of the granted source, plus pop decode
  always_comb begin
    head_rw   = 1'b0;
    head_pc   = '0;
    head_dst  = '0;
    head_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i] = grant_valid && (grant_idx == SRC_W'(i)) && !flush;
      if (grant_idx == SRC_W'(i)) begin
        head_rw   = rw_mem[i][rd_ptr_q[i][IDX_W-1:0]];
        head_pc   = pc_mem[i][rd_ptr_q[i][IDX_W-1:0]];
        head_dst  = dst_mem[i][rd_ptr_q[i][IDX_W-1:0]];
        head_data = data_mem[i][rd_ptr_q[i][IDX_W-1:0]];
      end
    end
  end

  // Pointer next-state; flush empties every FIFO and blocks push/pop
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      if (flush) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
      end else begin
        if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
        if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
      end
    end
  end

  // Pointer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO payload write; contents need no reset, pointers gate visibility
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        pc_mem[i][wr_ptr_q[i][IDX_W-1:0]]   <= src_pc[i*ADDR_W +: ADDR_W];
        rw_mem[i][wr_ptr_q[i][IDX_W-1:0]]   <= src_reg_write[i];
        dst_mem[i][wr_ptr_q[i][IDX_W-1:0]]  <= src_reg_dst[i*REG_AW +: REG_AW];
        data_mem[i][wr_ptr_q[i][IDX_W-1:0]] <= src_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Writeback register, arbiter state and retire counter next-state
  always_comb begin
    wb_valid_d     = 1'b0;
    wb_reg_write_d = 1'b0;
    wb_src_d       = wb_src_q;
    wb_pc_d        = wb_pc_q;
    wb_reg_dst_d   = wb_reg_dst_q;
    wb_wdata_d     = wb_wdata_q;
    last_grant_d   = last_grant_q;
    retired_d      = retired_q;
    if (flush) begin
      last_grant_d = SRC_W'(NUM_SRC - 1);
    end else if (grant_valid) begin
      wb_valid_d     = 1'b1;
      wb_src_d       = grant_idx;
      wb_pc_d        = head_pc;
      // Writes to $zero retire but never reach the regfile
      wb_reg_write_d = head_rw && (head_dst != '0);
      wb_reg_dst_d   = head_dst;
      wb_wdata_d     = head_data;
      last_grant_d   = grant_idx;
      retired_d      = retired_q + 32'd1;
    end
  end

  // Output and arbiter state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid_q     <= 1'b0;
      wb_src_q       <= '0;
      wb_pc_q        <= '0;
      wb_reg_write_q <= 1'b0;
      wb_reg_dst_q   <= '0;
      wb_wdata_q     <= '0;
      last_grant_q   <= SRC_W'(NUM_SRC - 1);
      retired_q      <= '0;
    end else begin
      wb_valid_q     <= wb_valid_d;
      wb_src_q       <= wb_src_d;
      wb_pc_q        <= wb_pc_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_reg_dst_q   <= wb_reg_dst_d;
      wb_wdata_q     <= wb_wdata_d;
      last_grant_q   <= last_grant_d;
      retired_q      <= retired_d;
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_src        = wb_src_q;
  assign wb_pc         = wb_pc_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_reg_dst    = wb_reg_dst_q;
  assign wb_wdata      = wb_wdata_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with a per-source scoreboard.
module tb_writeback_arbiter;

  localparam int NS = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            flush;
  logic [NS-1:0]   src_valid;
  logic [NS-1:0]   src_ready;
  logic [NS*32-1:0] src_pc;
  logic [NS-1:0]   src_reg_write;
  logic [NS*5-1:0] src_reg_dst;
  logic [NS*32-1:0] src_wdata;
  logic            wb_valid;
  logic [0:0]      wb_src;
  logic [31:0]     wb_pc;
  logic            wb_reg_write;
  logic [4:0]      wb_reg_dst;
  logic [31:0]     wb_wdata;
  logic [31:0]     retired_count;

  writeback_arbiter dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush         (flush),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .src_pc        (src_pc),
    .src_reg_write (src_reg_write),
    .src_reg_dst   (src_reg_dst),
    .src_wdata     (src_wdata),
    .wb_valid      (wb_valid),
    .wb_src        (wb_src),
    .wb_pc         (wb_pc),
    .wb_reg_write  (wb_reg_write),
    .wb_reg_dst    (wb_reg_dst),
    .wb_wdata      (wb_wdata),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        rw;
    logic [4:0]  dst;
    logic [31:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   glog[$];
  int   checks = 0;
  int   errors = 0;
  int   accepted = 0;
  int   discarded = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Retirements expected so far, valid when nothing is in flight
  function automatic int exp_retired();
    return accepted - discarded - q0.size() - q1.size();
  endfunction

  task automatic set_src(input int i, input logic v, input logic [31:0] pc, input logic rw,
                         input logic [4:0] dst, input logic [31:0] d);
    src_valid[i]          = v;
    src_pc[i*32 +: 32]    = pc;
    src_reg_write[i]      = rw;
    src_reg_dst[i*5 +: 5] = dst;
    src_wdata[i*32 +: 32] = d;
  endtask

  task automatic idle();
    flush         = 1'b0;
    src_valid     = '0;
    src_reg_write = '0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Scoreboard push: record accepted entries at the active edge
  always @(posedge clk) begin : pusher
    exp_t pe;
    if (reset_n === 1'b1) begin
      if (flush === 1'b1) begin
        discarded += q0.size() + q1.size();
        q0.delete();
        q1.delete();
      end else begin
        for (int i = 0; i < NS; i++) begin
          if (src_valid[i] && src_ready[i]) begin
            pe.pc   = src_pc[i*32 +: 32];
            pe.rw   = src_reg_write[i] && (src_reg_dst[i*5 +: 5] != 5'd0);
            pe.dst  = src_reg_dst[i*5 +: 5];
            pe.data = src_wdata[i*32 +: 32];
            accepted++;
            if (i == 0) q0.push_back(pe);
            else q1.push_back(pe);
          end
        end
      end
    end
  end

  // Scoreboard pop: every retirement must match the oldest entry of its source
  always @(negedge clk) begin : monitor
    exp_t me;
    logic have;
    if (reset_n === 1'b1 && wb_valid === 1'b1) begin
      glog.push_back(int'(wb_src));
      have = 1'b0;
      me   = '0;
      if (wb_src == 1'b0) begin
        have = (q0.size() > 0);
        if (have) me = q0.pop_front();
      end else begin
        have = (q1.size() > 0);
        if (have) me = q1.pop_front();
      end
      chk("sb_entry_available", 64'(have), 64'd1);
      if (have) begin
        chk("sb_pc", 64'(wb_pc), 64'(me.pc));
        chk("sb_reg_write", 64'(wb_reg_write), 64'(me.rw));
        chk("sb_reg_dst", 64'(wb_reg_dst), 64'(me.dst));
        chk("sb_wdata", 64'(wb_wdata), 64'(me.data));
      end
    end
  end

  always @(negedge reset_n) begin
    q0.delete();
    q1.delete();
    accepted  = 0;
    discarded = 0;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    int k;
    src_pc      = '0;
    src_reg_dst = '0;
    src_wdata   = '0;
    idle();
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_reg_write", 64'(wb_reg_write), 64'd0);
    chk("rst_wb_pc", 64'(wb_pc), 64'd0);
    chk("rst_wb_wdata", 64'(wb_wdata), 64'd0);
    chk("rst_retired", 64'(retired_count), 64'd0);
    chk("rst_ready", 64'(src_ready), 64'd3);
    reset_n = 1'b1;
    @(negedge clk);

    // Single push, two-cycle latency
    set_src(0, 1'b1, 32'h8000_0000, 1'b1, 5'd3, 32'hDEAD_BEEF);
    @(negedge clk);
    idle();
    chk("t1_not_yet", 64'(wb_valid), 64'd0);
    @(negedge clk);
    chk("t1_valid", 64'(wb_valid), 64'd1);
    chk("t1_src", 64'(wb_src), 64'd0);
    chk("t1_reg_write", 64'(wb_reg_write), 64'd1);
    chk("t1_dst", 64'(wb_reg_dst), 64'd3);
    chk("t1_retired", 64'(retired_count), 64'd1);
    @(negedge clk);
    chk("t1_idle_valid", 64'(wb_valid), 64'd0);
    chk("t1_idle_hold_pc", 64'(wb_pc), 64'h8000_0000);
    do_flush();

    // Fairness: both sources push for 8 cycles
    glog.delete();
    for (int c = 0; c < 8; c++) begin
      chk("t2_ready", 64'(src_ready), (c < 6) ? 64'd3 : ((c == 6) ? 64'd1 : 64'd2));
      set_src(0, 1'b1, 32'h1000 + 32'(c * 4), 1'b1, 5'(c + 1), 32'hA000 + 32'(c));
      set_src(1, 1'b1, 32'h2000 + 32'(c * 4), 1'b1, 5'(c + 9), 32'hB000 + 32'(c));
      @(negedge clk);
    end
    idle();
    repeat (20) @(negedge clk);
    chk("t2_grant_count", 64'(glog.size()), 64'd14);
    for (int g = 0; g < glog.size(); g++) chk("t2_alternate", 64'(glog[g]), 64'(g % 2));
    chk("t2_retired", 64'(retired_count), 64'(exp_retired()));
    chk("t2_retired_abs", 64'(retired_count), 64'd15);
    do_flush();

    // Full: src1 offers 6 entries, each held until accepted, src0 streams
    k = 0;
    for (int c = 0; c < 7; c++) begin
      chk("t3_ready", 64'(src_ready), (c < 6) ? 64'd3 : 64'd1);
      set_src(0, 1'b1, 32'h3000 + 32'(c * 4), 1'b1, 5'd7, 32'hC000 + 32'(c));
      set_src(1, (k < 6), 32'h4000 + 32'(k * 4), 1'b1, 5'd8, 32'hD000 + 32'(k));
      if (k < 6 && src_ready[1]) k++;
      @(negedge clk);
    end
    idle();
    chk("t3_src1_accepted", 64'(k), 64'd6);
    repeat (20) @(negedge clk);
    chk("t3_drained", 64'(q0.size() + q1.size()), 64'd0);
    chk("t3_retired", 64'(retired_count), 64'(exp_retired()));

    // $zero destination is retired without a regfile write
    set_src(0, 1'b1, 32'h5000, 1'b1, 5'd0, 32'h1234);
    @(negedge clk);
    idle();
    chk("t4_not_yet", 64'(wb_valid), 64'd0);
    @(negedge clk);
    chk("t4_valid", 64'(wb_valid), 64'd1);
    chk("t4_reg_write", 64'(wb_reg_write), 64'd0);
    chk("t4_wdata", 64'(wb_wdata), 64'h1234);
    repeat (3) @(negedge clk);

    // Flush with entries queued and a concurrent push
    for (int c = 0; c < 3; c++) begin
      set_src(0, 1'b1, 32'h6000 + 32'(c * 4), 1'b1, 5'd10, 32'hE000 + 32'(c));
      set_src(1, (c < 2), 32'h6100 + 32'(c * 4), 1'b1, 5'd11, 32'hF000 + 32'(c));
      @(negedge clk);
    end
    idle();
    set_src(0, 1'b1, 32'h6F00, 1'b1, 5'd12, 32'hBAD0);
    flush = 1'b1;
    @(negedge clk);
    idle();
    chk("t5_valid", 64'(wb_valid), 64'd0);
    chk("t5_reg_write", 64'(wb_reg_write), 64'd0);
    chk("t5_ready", 64'(src_ready), 64'd3);
    chk("t5_retired_kept", 64'(retired_count), 64'(exp_retired()));
    chk("t5_retired_abs", 64'(retired_count), 64'd31);
    repeat (2) @(negedge clk);
    chk("t5_no_stale", 64'(wb_valid), 64'd0);
    set_src(0, 1'b1, 32'h6200, 1'b1, 5'd13, 32'h1111);
    set_src(1, 1'b1, 32'h6300, 1'b1, 5'd14, 32'h2222);
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("t5_first_grant", 64'(wb_src), 64'd0);
    @(negedge clk);
    chk("t5_second_grant", 64'(wb_src), 64'd1);
    repeat (3) @(negedge clk);
    chk("t5_retired_after", 64'(retired_count), 64'(exp_retired()));

    // Asynchronous reset while a writeback is in progress
    for (int c = 0; c < 4; c++) begin
      set_src(0, 1'b1, 32'h7000 + 32'(c * 4), 1'b1, 5'd15, 32'h7700 + 32'(c));
      set_src(1, 1'b1, 32'h7100 + 32'(c * 4), 1'b1, 5'd16, 32'h7800 + 32'(c));
      @(negedge clk);
    end
    chk("t6_busy", 64'(wb_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_valid_now", 64'(wb_valid), 64'd0);
    chk("t6_retired_now", 64'(retired_count), 64'd0);
    chk("t6_ready_now", 64'(src_ready), 64'd3);
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t6_no_stale", 64'(wb_valid), 64'd0);
    end
    chk("t6_retired_zero", 64'(retired_count), 64'd0);
    set_src(1, 1'b1, 32'h7F00, 1'b1, 5'd17, 32'h7F7F);
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("t6_restart_valid", 64'(wb_valid), 64'd1);
    chk("t6_restart_src", 64'(wb_src), 64'd1);
    chk("t6_restart_retired", 64'(retired_count), 64'd1);
    repeat (2) @(negedge clk);
    chk("end_drained", 64'(q0.size() + q1.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
Parametrised writeback stage that merges completions from NUM_SRC producers (default 2: execute-direct and memory) into the single register-file write port.
- Each source has a valid/ready handshake into its own FIFO of depth DEPTH.
- A round-robin arbiter selects one FIFO head per cycle into a registered writeback output.
- Sits between the execute/memory stages and the regfile; adds flush, $zero suppression and a retired-instruction counter.

Parameters:
NUM_SRC, 2, number of completion sources (1..8)
DEPTH, 4, entries per source FIFO (power of two, >=2)
ADDR_W, 32, pc width
DATA_W, 32, writeback data width
REG_AW, 5, register index width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush
src_valid  in  NUM_SRC  per-source completion valid
src_ready  out  NUM_SRC  per-source FIFO can accept
src_pc  in  NUM_SRC*ADDR_W  packed per-source pc (source i at [i*ADDR_W +: ADDR_W])
src_reg_write  in  NUM_SRC  per-source register write enable
src_reg_dst  in  NUM_SRC*REG_AW  packed destination register index
src_wdata  in  NUM_SRC*DATA_W  packed writeback data (already muxed alu/load)
wb_valid  out  1  writeback slot occupied this cycle
wb_src  out  $clog2(NUM_SRC) (min 1)  index of the granted source
wb_pc  out  ADDR_W  pc of the retiring instruction
wb_reg_write  out  1  regfile write enable
wb_reg_dst  out  REG_AW  regfile write index
wb_wdata  out  DATA_W  regfile write data
retired_count  out  32  count of wb_valid cycles since reset

Behaviour:
- Reset (reset_n low, asynchronous): all FIFOs empty, all wb_* outputs 0, retired_count 0, last_grant = NUM_SRC-1 (source 0 has highest priority first).
- src_ready[i] = !full[i]. It depends only on occupancy, never on src_valid or the grant. Push when src_valid[i] && src_ready[i].
- A full FIFO deasserts ready even when it pops in the same cycle (no pass-through).
- Arbitration: requesters are the non-empty FIFOs. Priority starts at (last_grant+1) mod NUM_SRC and ascends with wrap. Exactly one head is popped per cycle when any FIFO is non-empty. last_grant updates only on a grant.
- Output register, loaded every edge:
  - With a grant: wb_valid=1, wb_src=granted index, wb_pc/wb_reg_dst/wb_wdata from the head entry, wb_reg_write = head.reg_write && (head.reg_dst != 0).
  - With no requester: wb_valid=0, wb_reg_write=0; other wb_* hold their previous values.
- Latency: an entry pushed at edge t into an empty FIFO with no competition is popped at edge t+1. wb_valid is high in the cycle after edge t+1. Minimum latency is 2 cycles.
- No downstream backpressure: the regfile always accepts.
- Per-source order is preserved (FIFO). Cross-source order is arbitration order only.
- Push and pop on the same FIFO in the same cycle are both honoured; occupancy is unchanged.
- FIFO pointers are log2(DEPTH)+1 bits wide and wrap naturally. full = same index with opposite MSB; empty = pointers equal.
- flush (sampled at the edge), taking priority over push and pop:
  - all FIFOs empty; src inputs in that cycle are dropped; no pop.
  - wb_valid=0 and wb_reg_write=0 next cycle.
  - last_grant = NUM_SRC-1.
  - retired_count unaffected.
- retired_count increments by 1 at each edge where wb_valid is loaded as 1; wraps 0xFFFFFFFF->0.
- A reset_n assertion mid-operation discards all queued entries immediately; no partial writes are emitted.

Test Plan:
- Reset then single push: src0 pc=0x80000000, dst=3, wdata=0xDEADBEEF at edge t -> wb_valid=1 in cycle after edge t+1, wb_src=0, wb_reg_write=1, wb_reg_dst=3, retired_count=1.
- Fairness: both sources push every cycle for 8 cycles -> wb_src alternates 0,1,0,1…; src_ready never drops for DEPTH=4 before each source holds 4 entries net.
- Full: src1 pushes 6 consecutive entries while src0 streams continuously -> src_ready[1]=0 once 4 entries are held. Entries are accepted only when ready; wb_pc order for source 1 matches acceptance order.
- $zero: push dst=0, reg_write=1, wdata=0x1234 -> wb_valid=1, wb_reg_write=0.
- Flush: 3 entries queued in src0 and 2 in src1, assert flush one cycle while src0 also pushes -> next cycle wb_valid=0, src_ready=all 1s. The subsequent first grant goes to source 0; retired_count keeps its pre-flush value.
- Async reset mid-stream: drop reset_n between edges while wb_valid=1 -> wb_valid=0 and retired_count=0 immediately; after release the FIFOs are empty and no stale entry retires.
